// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants and state encoding for the div_seq_32 divider.
// WIDTH is the operand width and is fixed to the adder_32 datapath.
// CNT_W is the width of the iteration counter and must hold WIDTH.

package div_seq_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    // state   | meaning
    // S_IDLE  | waiting for an operand transfer, start_ready high
    // S_RUN   | one restoring-division step per cycle, 32 steps
    // S_FIX   | sign correction of quotient/remainder (signed build only)
    // S_DONE  | result presented on res_valid until res_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/adder_32.sv
// adder_32: 32-bit adder/subtractor shared with the ALU datapath.
// cin=1 selects subtract: sum = a + ~b + 1 = a - b, cout=1 means no borrow.
// overflow reports signed overflow of the effective operation.

module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);

    logic [31:0] b_eff;
    logic [32:0] full;

    assign b_eff    = cin ? ~b : b;
    assign full     = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin};
    assign sum      = full[31:0];
    assign cout     = full[32];
    assign overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/div_seq_32.sv
// div_seq_32: iterative restoring divider, one quotient bit per cycle.
// A single adder_32 (u_sub) acts as the trial subtractor every RUN cycle.
// Optional feature macro: DIV_SIGNED_EN enables signed division via a
// one-cycle FIX state; without it signed_op is ignored and all ops are
// unsigned.

module div_seq_32
    import div_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    input  logic             flush,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [1:0]       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] cnt;
    logic             dbz;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] sub_sum;
    logic             sub_cout;
    logic             sub_ovf_unused;
    logic             qbit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_step;

`ifdef DIV_SIGNED_EN
    logic             neg_q;
    logic             neg_r;

    assign a_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
`else
    logic             signed_op_unused;

    assign signed_op_unused = signed_op;
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    // {rem,q} shifted left; bit WIDTH set means the trial value already exceeds divisor
    assign rem_sh    = {rem, q[WIDTH-1]};
    assign qbit      = sub_cout | rem_sh[WIDTH];
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    adder_32 u_sub (
        .a        (rem_sh[WIDTH-1:0]),
        .b        (dvsr),
        .cin      (1'b1),
        .sum      (sub_sum),
        .cout     (sub_cout),
        .overflow (sub_ovf_unused)
    );

    assign start_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign res_valid   = (state == S_DONE);
    assign quotient    = q;
    assign remainder   = rem;
    assign div_by_zero = dbz;

    // Sequencer: operand load, division steps, sign fix-up and result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
            q     <= '0;
            dvsr  <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        cnt  <= '0;
                        dvsr <= b_mag;
                        if (divisor == '0) begin
                            // zero divisor bypasses RUN; remainder is the raw dividend
                            q     <= '1;
                            rem   <= dividend;
                            dbz   <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            q     <= a_mag;
                            rem   <= '0;
                            dbz   <= 1'b0;
                            state <= S_RUN;
                        end
`ifdef DIV_SIGNED_EN
                        neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op && dividend[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    rem <= qbit ? sub_sum : rem_sh[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], qbit};
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
`ifdef DIV_SIGNED_EN
                        state <= S_FIX;
`else
                        state <= S_DONE;
`endif
                    end
                end
                S_FIX: begin
`ifdef DIV_SIGNED_EN
                    if (neg_q) q <= -q;
                    if (neg_r) rem <= -rem;
`endif
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
